// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load unit (B), plus a zero-fill clear sequencer.
// Optional: define RF_ZERO_PROTECT_EN to suppress requester writes to x0.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(NREGS - 1);

  state_t          state, state_next;
  logic            prio;
  logic [ADDR_W:0] idx;
  logic            a_acc, b_acc;
  logic            a_wr_ok, b_wr_ok;

`ifdef RF_ZERO_PROTECT_EN
  assign a_wr_ok = (a_rd != '0);
  assign b_wr_ok = (b_rd != '0);
`else
  assign a_wr_ok = 1'b1;
  assign b_wr_ok = 1'b1;
`endif

  assign clear_busy = (state == CLEAR);
  assign a_acc      = a_valid & a_ready;
  assign b_acc      = b_valid & b_ready;

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      ARB: begin
        if (!reset) begin
          if (clear_start) begin
            state_next = CLEAR;
          end else if (a_valid && b_valid) begin
            a_ready = ~prio;
            b_ready = prio;
          end else begin
            a_ready = a_valid;
            b_ready = b_valid;
          end
        end
      end
      CLEAR: begin
        if (idx == IDX_LAST) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      prio       <= 1'b0;
      idx        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      wr_en      <= 1'b0;
      clear_done <= 1'b0;
      if (state == CLEAR) begin
        wr_en      <= 1'b1;
        wr_addr    <= idx[ADDR_W-1:0];
        wr_data    <= '0;
        clear_done <= (idx == IDX_LAST);
        idx        <= (idx == IDX_LAST) ? '0 : idx + (ADDR_W+1)'(1);
      end else begin
        idx <= '0;
        // A protected x0 write still completes its handshake and moves prio.
        if (a_acc) begin
          wr_en   <= a_wr_ok;
          wr_addr <= a_rd;
          wr_data <= a_data;
          prio    <= 1'b1;
        end else if (b_acc) begin
          wr_en   <= b_wr_ok;
          wr_addr <= b_rd;
          wr_data <= b_data;
          prio    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a reference model pushes expected port values per cycle, popped after the edge.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, wr_addr;
  logic [31:0] a_data, b_data, wr_data;
  logic        clear_start, clear_busy, clear_done, wr_en;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  byte         glog[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt;

  bit          m_clear = 0;
  bit          m_prio  = 0;
  int          m_idx   = 0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_allowed(input logic [4:0] rd);
`ifdef RF_ZERO_PROTECT_EN
    return rd != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    bit   ea, eb;
    exp_t e, o;
    @(negedge clk);
    ea = !reset && !m_clear && !clear_start && a_valid && (!b_valid || !m_prio);
    eb = !reset && !m_clear && !clear_start && b_valid && (!a_valid || m_prio);
    check("a_ready", 64'(a_ready), 64'(ea));
    check("b_ready", 64'(b_ready), 64'(eb));
    e.en = 1'b0;
    e.done = 1'b0;
    if (reset) begin
      m_clear = 0; m_prio = 0; m_idx = 0; m_addr = '0; m_data = '0;
    end else if (m_clear) begin
      e.en   = 1'b1;
      m_addr = 5'(m_idx);
      m_data = '0;
      e.done = (m_idx == 31);
      if (m_idx == 31) begin m_clear = 0; m_idx = 0; end
      else m_idx++;
    end else if (ea) begin
      e.en = wr_allowed(a_rd); m_addr = a_rd; m_data = a_data; m_prio = 1;
      glog.push_back("A");
    end else if (eb) begin
      e.en = wr_allowed(b_rd); m_addr = b_rd; m_data = b_data; m_prio = 0;
      glog.push_back("B");
    end else if (clear_start) begin
      m_clear = 1; m_idx = 0;
    end
    e.addr = m_addr;
    e.data = m_data;
    e.busy = m_clear;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      o = sb.pop_front();
      check("wr_en", 64'(wr_en), 64'(o.en));
      check("wr_addr", 64'(wr_addr), 64'(o.addr));
      check("wr_data", 64'(wr_data), 64'(o.data));
      check("clear_done", 64'(clear_done), 64'(o.done));
      check("clear_busy", 64'(clear_busy), 64'(o.busy));
    end
    if (clear_done) done_cnt++;
  endtask

  initial begin
    logic [4:0] seq [4];
    reset = 1; clear_start = 0;
    a_valid = 1; a_rd = 5'd3; a_data = 32'h1111_0003;
    b_valid = 1; b_rd = 5'd4; b_data = 32'h2222_0004;

    // reset held with both requesters valid
    step(); step();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    reset = 0;
    glog.delete();
    step();
    check("first_grant_A", 64'(glog.size() == 1 && glog[0] == "A"), 64'd1);

    // single requester A
    b_valid = 0; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    step();
    check("single_en", 64'(wr_en), 64'd1);
    check("single_addr", 64'(wr_addr), 64'd5);
    check("single_data", 64'(wr_data), 64'hDEAD_BEEF);
    a_valid = 0;
    step();
    check("single_idle", 64'(wr_en), 64'd0);

    // lone B grant returns prio to A
    b_valid = 1; b_rd = 5'd9; b_data = 32'h0000_0009;
    step();
    b_valid = 0;
    step();

    // contention fairness
    glog.delete();
    a_valid = 1; a_rd = 5'd1; a_data = 32'hA1;
    b_valid = 1; b_rd = 5'd2; b_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      step();
      seq[i] = wr_addr;
    end
    check("fair_order", 64'(glog.size() == 4 && glog[0] == "A" && glog[1] == "B"
                            && glog[2] == "A" && glog[3] == "B"), 64'd1);
    check("fair_addr", {44'd0, seq[0], seq[1], seq[2], seq[3]},
          {44'd0, 5'd1, 5'd2, 5'd1, 5'd2});

    // clear with both requesters valid, then back-to-back grant
    done_cnt = 0;
    clear_start = 1;
    step();
    clear_start = 0;
    for (int i = 0; i < 34; i++) step();
    check("clear_done_cnt", 64'(done_cnt), 64'd1);
    a_valid = 0; b_valid = 0;
    step(); step();

    // reset in the middle of a clear
    clear_start = 1;
    step();
    clear_start = 0;
    for (int i = 0; i < 9; i++) step();
    reset = 1;
    step();
    check("midclr_en", 64'(wr_en), 64'd0);
    check("midclr_busy", 64'(clear_busy), 64'd0);
    reset = 0;
    for (int i = 0; i < 5; i++) step();

    // requester write to x0
    b_valid = 1; b_rd = 5'd0; b_data = 32'd7;
    step();
`ifdef RF_ZERO_PROTECT_EN
    check("x0_en", 64'(wr_en), 64'd0);
`else
    check("x0_en", 64'(wr_en), 64'd1);
    check("x0_addr", 64'(wr_addr), 64'd0);
    check("x0_data", 64'(wr_data), 64'd7);
`endif
    b_valid = 0;
    step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
